// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM (ram_dp_param).
// Helpers work on maximum-width vectors; callers zero-extend and size-cast.
package ram_pkg;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} ram_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int BYTES      = DEF_DATA_W / 8;
  localparam int MAX_W      = 1024;
  localparam int MAX_BYTES  = MAX_W / 8;
  localparam int MAX_ADDR_W = 64;

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]     old_w,
                                                  input logic [MAX_W-1:0]     new_w,
                                                  input logic [MAX_BYTES-1:0] we);
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (we[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned           shift);
    return addr >> shift;
  endfunction

  // Even parity per byte: the stored bit makes the 9-bit group even.
  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_W-1:0] w);
    logic [MAX_BYTES-1:0] p;
    for (int i = 0; i < MAX_BYTES; i++) p[i] = ^w[i*8 +: 8];
    return p;
  endfunction
endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: walks every word once, writing the init value,
// then hands the RAM over to the ports. State is exported for observation.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic             init_busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr,
  output ram_state_e       state
);
  ram_state_e       state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + IDX_W'(1);
        end
      end
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  assign clr_addr = cnt;
endmodule

// File: rtl/ram_dp_param.sv
// Parametrised two-port RAM: port A read-only fetch, port B byte-enabled load/store.
// Optional per-byte even parity with error reporting when RAM_PARITY_EN is defined.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               DEPTH    = 1024,
  parameter int               ADDR_W   = 32,
  parameter int               RDW_MODE = 0,
  parameter int               OUT_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_en,
  input  logic [ADDR_W-1:0]   a_addr,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  output logic                a_oob,
  input  logic                b_en,
  input  logic [DATA_W/8-1:0] b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                b_oob,
  output logic                init_busy
`ifdef RAM_PARITY_EN
  ,
  input  logic                inj_perr,
  output logic                a_perr,
  output logic                b_perr
`endif
);
  localparam int          NBYTES = DATA_W / 8;
  localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SHIFT  = $clog2(NBYTES);

  logic [DATA_W-1:0]     mem [DEPTH];
  ram_state_e            init_state;
  logic                  clr_we;
  logic [IDX_W-1:0]      clr_addr;
  logic [MAX_ADDR_W-1:0] a_wi, b_wi;
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  a_acc, b_acc, a_oob_c, b_oob_c, b_wr, a_hit, b_hit;
  logic [DATA_W-1:0]     a_rd_c, b_rd_c;
  logic                  a_v1, a_v2, b_v1, b_v2, a_o1, a_o2, b_o1, b_o2;
  logic [DATA_W-1:0]     a_d1, a_d2, b_d1, b_d2;

  ram_init_seq #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_init (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state     (init_state)
  );

  assign a_wi    = word_index(MAX_ADDR_W'(a_addr), SHIFT);
  assign b_wi    = word_index(MAX_ADDR_W'(b_addr), SHIFT);
  assign a_oob_c = a_wi >= MAX_ADDR_W'(DEPTH);
  assign b_oob_c = b_wi >= MAX_ADDR_W'(DEPTH);
  assign a_idx   = IDX_W'(a_wi);
  assign b_idx   = IDX_W'(b_wi);
  assign a_acc   = a_en && (init_state == ST_RUN);
  assign b_acc   = b_en && (init_state == ST_RUN);
  assign b_wr    = b_acc && (|b_we) && !b_oob_c;
  // New-data policy only differs from old-data when this cycle's write lands on the read word.
  assign a_hit   = (RDW_MODE == 1) && b_wr && (a_idx == b_idx);
  assign b_hit   = (RDW_MODE == 1) && b_wr;

  always_comb begin
    a_rd_c = '0;
    b_rd_c = '0;
    if (!a_oob_c) begin
      a_rd_c = a_hit ? DATA_W'(byte_merge(MAX_W'(mem[a_idx]), MAX_W'(b_wdata), MAX_BYTES'(b_we)))
                     : mem[a_idx];
    end
    if (!b_oob_c) begin
      b_rd_c = b_hit ? DATA_W'(byte_merge(MAX_W'(mem[b_idx]), MAX_W'(b_wdata), MAX_BYTES'(b_we)))
                     : mem[b_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (b_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (b_we[i]) mem[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  // Data/oob registers only load on a response so outputs hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_v1 <= 1'b0; a_v2 <= 1'b0; b_v1 <= 1'b0; b_v2 <= 1'b0;
      a_o1 <= 1'b0; a_o2 <= 1'b0; b_o1 <= 1'b0; b_o2 <= 1'b0;
      a_d1 <= '0;   a_d2 <= '0;   b_d1 <= '0;   b_d2 <= '0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      a_v2 <= a_v1;
      b_v2 <= b_v1;
      if (a_acc) begin a_d1 <= a_rd_c; a_o1 <= a_oob_c; end
      if (b_acc) begin b_d1 <= b_rd_c; b_o1 <= b_oob_c; end
      if (a_v1)  begin a_d2 <= a_d1;   a_o2 <= a_o1;    end
      if (b_v1)  begin b_d2 <= b_d1;   b_o2 <= b_o1;    end
    end
  end

  assign a_rvalid = (OUT_REG == 1) ? a_v2 : a_v1;
  assign a_rdata  = (OUT_REG == 1) ? a_d2 : a_d1;
  assign a_oob    = (OUT_REG == 1) ? a_o2 : a_o1;
  assign b_rvalid = (OUT_REG == 1) ? b_v2 : b_v1;
  assign b_rdata  = (OUT_REG == 1) ? b_d2 : b_d1;
  assign b_oob    = (OUT_REG == 1) ? b_o2 : b_o1;

`ifdef RAM_PARITY_EN
  logic [NBYTES-1:0] par [DEPTH];
  logic [NBYTES-1:0] b_wpar, a_pr_c, b_pr_c;
  logic              a_pe_c, b_pe_c, a_pe1, a_pe2, b_pe1, b_pe2;

  // Stored parity view follows the same read-during-write rule as the data.
  always_comb begin
    b_wpar = NBYTES'(byte_parity(MAX_W'(b_wdata))) ^ {NBYTES{inj_perr}};
    a_pr_c = '0;
    b_pr_c = '0;
    if (!a_oob_c) a_pr_c = a_hit ? ((par[a_idx] & ~b_we) | (b_wpar & b_we)) : par[a_idx];
    if (!b_oob_c) b_pr_c = b_hit ? ((par[b_idx] & ~b_we) | (b_wpar & b_we)) : par[b_idx];
    a_pe_c = !a_oob_c && (|(a_pr_c ^ NBYTES'(byte_parity(MAX_W'(a_rd_c)))));
    b_pe_c = !b_oob_c && (|(b_pr_c ^ NBYTES'(byte_parity(MAX_W'(b_rd_c)))));
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      par[clr_addr] <= NBYTES'(byte_parity(MAX_W'(INIT_VAL)));
    end else if (b_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (b_we[i]) par[b_idx][i] <= b_wpar[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_pe1 <= 1'b0; a_pe2 <= 1'b0; b_pe1 <= 1'b0; b_pe2 <= 1'b0;
    end else begin
      if (a_acc) a_pe1 <= a_pe_c;
      if (b_acc) b_pe1 <= b_pe_c;
      if (a_v1)  a_pe2 <= a_pe1;
      if (b_v1)  b_pe2 <= b_pe1;
    end
  end

  assign a_perr = a_rvalid && ((OUT_REG == 1) ? a_pe2 : a_pe1);
  assign b_perr = b_rvalid && ((OUT_REG == 1) ? b_pe2 : b_pe1);
`endif
endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two instances (old-data/latency 1, new-data/latency 2)
// driven in parallel and checked every cycle against a word-level reference model.
module tb_ram_dp_param;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT0 = 32'h0000_0000;
  localparam logic [31:0] INIT1 = 32'h5A5A_0FF0;

  typedef struct packed {
    logic [31:0] due;
    logic        oob;
    logic        perr;
    logic [31:0] data;
  } resp_t;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, a_en = 1'b0, b_en = 1'b0, inj_perr = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0, b_wdata = '0;
  logic [3:0]  b_we = '0;

  logic [31:0] a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic        a_rvalid0, b_rvalid0, a_oob0, b_oob0, init_busy0;
  logic        a_rvalid1, b_rvalid1, a_oob1, b_oob1, init_busy1;
`ifdef RAM_PARITY_EN
  logic        a_perr0, b_perr0, a_perr1, b_perr1;
`endif

  ram_dp_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RDW_MODE(0), .OUT_REG(0),
                 .INIT_VAL(INIT0)) dut0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata0), .a_rvalid(a_rvalid0), .a_oob(a_oob0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0), .b_oob(b_oob0),
    .init_busy(init_busy0)
`ifdef RAM_PARITY_EN
    , .inj_perr(inj_perr), .a_perr(a_perr0), .b_perr(b_perr0)
`endif
  );

  ram_dp_param #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .RDW_MODE(1), .OUT_REG(1),
                 .INIT_VAL(INIT1)) dut1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata1), .a_rvalid(a_rvalid1), .a_oob(a_oob1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1), .b_oob(b_oob1),
    .init_busy(init_busy1)
`ifdef RAM_PARITY_EN
    , .inj_perr(inj_perr), .a_perr(a_perr1), .b_perr(b_perr1)
`endif
  );

  // reference model state: queue index = instance*2 + port (0 = A, 1 = B)
  logic [31:0] ref_mem [2][DEPTH];
  logic [3:0]  ref_bad [DEPTH];
  resp_t       exp_q [4][$];
  logic [31:0] last_data [4];
  int          busy_left = 0;
  int unsigned edge_n = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  // Applies the request sampled at this edge; instance d has latency d+1.
  task automatic model_edge();
    logic [31:0] ai, bi, wi, m, rd;
    logic [3:0]  pb;
    logic        ao, bo, oob, wr;
    resp_t       r;
    if (rst) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        ref_mem[0][i] = INIT0;
        ref_mem[1][i] = INIT1;
        ref_bad[i]    = 4'b0;
      end
      for (int q = 0; q < 4; q++) begin
        exp_q[q].delete();
        last_data[q] = '0;
      end
      return;
    end
    if (busy_left > 0) begin
      busy_left--;
      return;
    end
    ai = a_addr >> 2;
    bi = b_addr >> 2;
    ao = ai >= DEPTH;
    bo = bi >= DEPTH;
    wr = b_en && (b_we != 4'b0) && !bo;
    m  = lane_mask(b_we);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? a_en : b_en) begin
          wi  = (p == 0) ? ai : bi;
          oob = (p == 0) ? ao : bo;
          rd  = oob ? 32'h0 : ref_mem[d][wi];
          pb  = oob ? 4'h0 : ref_bad[wi];
          if (d == 1 && wr && wi == bi) begin
            rd = (rd & ~m) | (b_wdata & m);
            pb = (pb & ~b_we) | (inj_perr ? b_we : 4'h0);
          end
          r.due  = edge_n + d;
          r.oob  = oob;
          r.perr = |pb;
          r.data = rd;
          exp_q[d*2+p].push_back(r);
        end
      end
    end
    if (wr) begin
      for (int d = 0; d < 2; d++) ref_mem[d][bi] = (ref_mem[d][bi] & ~m) | (b_wdata & m);
      ref_bad[bi] = (ref_bad[bi] & ~b_we) | (inj_perr ? b_we : 4'h0);
    end
  endtask

  // scoreboard: compares every output of both instances against the model
  task automatic check_outputs();
    logic [31:0] gd;
    logic        gv, go, gp;
    bit          ev;
    resp_t       r;
    chk("busy0", {31'b0, init_busy0}, {31'b0, busy_left > 0});
    chk("busy1", {31'b0, init_busy1}, {31'b0, busy_left > 0});
    for (int q = 0; q < 4; q++) begin
      gp = 1'b0;
      case (q)
        0:       begin gv = a_rvalid0; gd = a_rdata0; go = a_oob0; end
        1:       begin gv = b_rvalid0; gd = b_rdata0; go = b_oob0; end
        2:       begin gv = a_rvalid1; gd = a_rdata1; go = a_oob1; end
        default: begin gv = b_rvalid1; gd = b_rdata1; go = b_oob1; end
      endcase
`ifdef RAM_PARITY_EN
      case (q)
        0:       gp = a_perr0;
        1:       gp = b_perr0;
        2:       gp = a_perr1;
        default: gp = b_perr1;
      endcase
`endif
      while (exp_q[q].size() > 0 && exp_q[q][0].due < edge_n) void'(exp_q[q].pop_front());
      ev = (exp_q[q].size() > 0) && (exp_q[q][0].due == edge_n);
      chk($sformatf("q%0d_rvalid", q), {31'b0, gv}, {31'b0, ev});
      if (ev) begin
        r = exp_q[q].pop_front();
        chk($sformatf("q%0d_rdata", q), gd, r.data);
        chk($sformatf("q%0d_oob", q), {31'b0, go}, {31'b0, r.oob});
`ifdef RAM_PARITY_EN
        chk($sformatf("q%0d_perr", q), {31'b0, gp}, {31'b0, r.perr});
`endif
        last_data[q] = r.data;
      end else begin
        chk($sformatf("q%0d_hold", q), gd, last_data[q]);
        if (gv == 1'b0) chk($sformatf("q%0d_perr_idle", q), {31'b0, gp}, 32'h0);
      end
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    edge_n++;
  endtask

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; b_we = 4'h0; inj_perr = 1'b0;
  endtask

  task automatic wr_b(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we,
                      input logic inj);
    idle();
    b_en = 1'b1; b_addr = addr; b_wdata = data; b_we = we; inj_perr = inj;
    cycle();
    idle();
  endtask

  task automatic rd_ab(input logic [31:0] addr);
    idle();
    a_en = 1'b1; a_addr = addr; b_en = 1'b1; b_addr = addr;
    cycle();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    a_en = 1'b1; a_addr = 32'h8;
    repeat (19) cycle();
    idle();

    for (int i = 0; i < DEPTH; i++) begin
      a_en = 1'b1; a_addr = i * 4; b_en = 1'b1; b_addr = (DEPTH - 1 - i) * 4;
      cycle();
    end
    idle();
    repeat (2) cycle();

    wr_b(32'h8, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    rd_ab(32'h8);
    wr_b(32'h8, 32'h0000_00AA, 4'b0001, 1'b0);
    rd_ab(32'h8);
    repeat (2) cycle();

    wr_b(32'h4, 32'h1122_3344, 4'b1111, 1'b0);
    a_en = 1'b1; a_addr = 32'h4;
    b_en = 1'b1; b_addr = 32'h4; b_wdata = 32'hAABB_CCDD; b_we = 4'b0011;
    cycle();
    idle();
    rd_ab(32'h4);
    repeat (2) cycle();

    rd_ab(32'h40);
    wr_b(32'h40, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    for (int i = 0; i < DEPTH; i++) rd_ab(i * 4 + (i % 4));
    repeat (2) cycle();

    rst = 1'b1; cycle(); rst = 1'b0;
    a_en = 1'b1; a_addr = 32'h8;
    repeat (5) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (18) cycle();
    idle();
    repeat (2) cycle();

    for (int n = 0; n < 800; n++) begin
      rst     = ($urandom_range(0, 249) == 0);
      a_en    = $urandom_range(0, 1);
      a_addr  = $urandom_range(0, 'h4F);
      b_en    = $urandom_range(0, 1);
      b_addr  = ($urandom_range(0, 3) == 0) ? a_addr : $urandom_range(0, 'h4F);
      b_we    = $urandom_range(0, 15);
      b_wdata = $urandom;
`ifdef RAM_PARITY_EN
      inj_perr = ($urandom_range(0, 7) == 0);
`endif
      cycle();
    end
    rst = 1'b0;
    idle();
    repeat (20) cycle();

`ifdef RAM_PARITY_EN
    wr_b(32'hC, 32'h1234_5678, 4'b1111, 1'b1);
    rd_ab(32'hC);
    repeat (2) cycle();
    wr_b(32'hC, 32'h1234_5678, 4'b1111, 1'b0);
    rd_ab(32'hC);
    repeat (2) cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dp_param.md
Name: ram_dp_param

Overview:
- Parametrised successor to the core's two-port unified RAM: port A is a read-only fetch port; port B is a load/store port with byte enables.
- Adds configurable width and depth, a selectable read-during-write policy, out-of-range detection and an optional output register.
- Adds a post-reset clear sequencer so memory contents are defined before the core runs.
- Sits between the fetch/LSU stages and backing storage in simulation and FPGA builds.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words.
- ADDR_W, 32, byte-address width on both ports.
- RDW_MODE, 0, read-during-write policy on an address match: 0 = return old data, 1 = return new data, merged per byte.
- OUT_REG, 0, 1 adds an output pipeline register on both ports, giving read latency 2.
- INIT_VAL, 0, word value written to every location by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- a_en  in  1  port A read request.
- a_addr  in  ADDR_W  port A byte address; word index = a_addr[ADDR_W-1:log2(DATA_W/8)].
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rdata is valid this cycle.
- a_oob  out  1  the request that produced this response was out of range.
- b_en  in  1  port B request (read, or write if any b_we bit is set).
- b_we  in  DATA_W/8  port B byte write enables.
- b_addr  in  ADDR_W  port B byte address.
- b_wdata  in  DATA_W  port B write data.
- b_rdata  out  DATA_W  port B read data; pre-write or merged per RDW_MODE.
- b_rvalid  out  1  b_rdata is valid this cycle.
- b_oob  out  1  the request that produced this response was out of range.
- init_busy  out  1  clear sequencer active; all requests are ignored.

Behaviour:
- Reset values: a_rdata = b_rdata = 0; a_rvalid = b_rvalid = a_oob = b_oob = 0; init_busy = 1 in the cycle after rst is sampled high.
- FSM states: INIT, RUN.
  - rst forces INIT with the clear counter at 0.
  - In INIT, one word per cycle: mem[cnt] <= INIT_VAL, cnt increments.
  - When cnt = DEPTH-1 the word is written, the next state is RUN, and init_busy drops that edge.
  - Clear duration: exactly DEPTH cycles.
  - rst asserted mid-INIT or in RUN restarts INIT from word 0.
- While in INIT, a_en and b_en are ignored and no rvalid is produced.
- Read latency:
  - OUT_REG = 0: rvalid and data appear on the edge after the request cycle (1 cycle).
  - OUT_REG = 1: 2 cycles; both pipeline stages reset to invalid.
- a_rdata and b_rdata hold their last value when no response is issued; rvalid pulses for one cycle per accepted request.
- A write asserts b_rvalid and returns read data as well; every accepted request produces exactly one response.
- Out of range (word index ≥ DEPTH):
  - Write is suppressed.
  - Read data is 0.
  - The response carries oob = 1.
- Address-match handling:
  - Port B write + port B read of the same word in the same cycle, RDW_MODE = 0: b_rdata = pre-write word. RDW_MODE = 1: b_rdata = bytes with b_we set taken from b_wdata, the rest from the old word.
  - Port A read of the word port B writes in the same cycle follows the same RDW_MODE rule.
- Only port B writes, so there are no write-write conflicts.
- Low address bits below word granularity are ignored; there is no misalignment detection.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - One even-parity bit per byte is stored alongside the data and written with each byte lane; the clear sequencer writes parity matching INIT_VAL.
  - Extra outputs a_perr and b_perr, width 1, are asserted with rvalid when any read byte's parity mismatches.
  - A debug input inj_perr, width 1, flips stored parity on the next port B write.
- Undefined: no parity storage, no perr ports, no inj_perr port.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state enum (INIT, RUN).
  - Function byte_merge(old, new, we).
  - Function word_index(addr).
  - Constant BYTES = DATA_W/8.
- Sub-module ram_init_seq: the clear counter and FSM, driving init_busy, the clear write enable and the clear address.
- Storage and port logic stay in ram_dp_param.

Test Plan:
- Reset then idle, DEPTH = 16 → init_busy high for exactly 16 cycles; reads of all 16 words return INIT_VAL = 0 with rvalid 1 cycle after request.
- Write 0xDEADBEEF at addr 0x8, we = 4'b1111; then read via A and B → both return 0xDEADBEEF; a second write of 0x000000AA with we = 4'b0001 gives 0xDEADBEAA.
- RDW: mem[0x4] = 0x11223344; B writes 0xAABBCCDD with we = 4'b0011 while A reads 0x4 → RDW_MODE = 0 gives 0x11223344; RDW_MODE = 1 gives 0x1122CCDD on both ports.
- Out of range: DEPTH = 16, read addr 0x40 → rdata = 0, oob = 1; write to 0x40 leaves all words unchanged.
- Reset asserted at clear cycle 5, then a_en during INIT → sequencer restarts (16 more busy cycles) and no a_rvalid is produced; with OUT_REG = 1, latency is 2 cycles.
- RAM_PARITY_EN: write with inj_perr = 1, then read the same word → b_perr = 1 with b_rvalid; a clean rewrite clears the error.
